// File: rtl/cim_tree_sequencer_if.sv
// cim_tree_sequencer_if
// Groups the job-control, producer, tree and consumer signals of the CIM
// adder-tree sequencer.
//   slave  : the sequencer itself (drives in_ready, tree_data, out_*, busy)
//   master : the surrounding environment (array readout, tree, core)
// Signals:
//   start / num_passes / shift_mode : job request, latched in IDLE
//   in_valid / in_ready / in_data   : producer beat handshake
//   tree_data / tree_sum            : tree input drive and tree result
//   out_valid / out_ready / out_acc : job result handshake
//   busy                            : sequencer not idle
interface cim_tree_sequencer_if #(
  parameter int NUM_LANES = 36,
  parameter int LANE_W    = 5,
  parameter int SUM_W     = 10,
  parameter int ACC_W     = 16
);
  logic                           start;
  logic [3:0]                     num_passes;
  logic                           shift_mode;
  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_LANES*LANE_W-1:0]    in_data;
  logic [NUM_LANES*LANE_W-1:0]    tree_data;
  logic signed [SUM_W-1:0]        tree_sum;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [ACC_W-1:0]        out_acc;
  logic                           busy;

  modport slave (
    input  start, num_passes, shift_mode, in_valid, in_data, tree_sum, out_ready,
    output in_ready, tree_data, out_valid, out_acc, busy
  );

  modport master (
    output start, num_passes, shift_mode, in_valid, in_data, tree_sum, out_ready,
    input  in_ready, tree_data, out_valid, out_acc, busy
  );
endinterface

// File: rtl/cim_tree_sequencer.sv
// cim_tree_sequencer
// Streams 1-16 beats of 36 signed 5-bit lanes into the CIM adder tree,
// tracks each beat through the tree latency with a tag pipe and folds the
// returned sums into a signed accumulator (plain or bit-serial MSB-first).
// Ports:
//   clk  : clock
//   RSTN : synchronous active-low reset (shared with the tree)
//   bus  : cim_tree_sequencer_if.slave, job/producer/tree/consumer signals
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; in_ready=0
// FEED  | accepting beats until num_passes+1 have been issued
// DRAIN | all beats issued, waiting for outstanding tags to retire
// DONE  | out_valid=1 with stable out_acc until out_ready
module cim_tree_sequencer #(
  parameter int NUM_LANES = 36,
  parameter int LANE_W    = 5,
  parameter int SUM_W     = 10,
  parameter int TREE_LAT  = 4,
  parameter int ACC_W     = 16
) (
  input  logic                  clk,
  input  logic                  RSTN,
  cim_tree_sequencer_if.slave   bus
);

  localparam int DATA_W = NUM_LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [4:0]              issued_q;
  logic [4:0]              retired_q;
  logic [3:0]              npass_q;
  logic                    mode_q;
  logic [TREE_LAT:0]       tag_q;
  logic [DATA_W-1:0]       tree_data_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] out_acc_q;

  logic                    in_ready;
  logic                    accept;
  logic                    retire;
  logic                    last_beat;
  logic                    last_retire;
  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] acc_d;

  // in_ready depends on registered state only; the counter runs to 16 so it
  // needs one bit more than num_passes.
  assign in_ready    = (state_q == FEED) && (issued_q <= {1'b0, npass_q});
  assign accept      = bus.in_valid && in_ready;
  assign last_beat   = accept && (issued_q == {1'b0, npass_q});
  // The tag leaving the pipe marks the edge at which tree_sum belongs to it.
  assign retire      = tag_q[TREE_LAT];
  assign last_retire = retire && (retired_q == {1'b0, npass_q});
  assign sum_ext     = {{(ACC_W-SUM_W){bus.tree_sum[SUM_W-1]}}, bus.tree_sum};

  always_comb begin
    acc_d = acc_q;
    if (retire) begin
      if (mode_q) begin
        // Bit-serial MSB-first: first plane is the sign plane (negative weight).
        if (retired_q == 5'd0) acc_d = -sum_ext;
        else                   acc_d = (acc_q <<< 1) + sum_ext;
      end else begin
        if (retired_q == 5'd0) acc_d = sum_ext;
        else                   acc_d = acc_q + sum_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      issued_q    <= '0;
      retired_q   <= '0;
      npass_q     <= '0;
      mode_q      <= 1'b0;
      tag_q       <= '0;
      tree_data_q <= '0;
      acc_q       <= '0;
      out_acc_q   <= '0;
    end else begin
      tag_q <= {tag_q[TREE_LAT-1:0], accept};
      acc_q <= acc_d;
      if (retire) retired_q <= retired_q + 5'd1;
      if (accept) begin
        tree_data_q <= bus.in_data;
        issued_q    <= issued_q + 5'd1;
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= FEED;
            npass_q   <= bus.num_passes;
            mode_q    <= bus.shift_mode;
            issued_q  <= '0;
            retired_q <= '0;
          end
        end
        FEED: begin
          if (last_beat) state_q <= DRAIN;
        end
        DRAIN: begin
          if (last_retire) begin
            state_q   <= DONE;
            out_acc_q <= acc_d;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.tree_data = tree_data_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_acc   = out_acc_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cim_tree_sequencer.sv
module tb_cim_tree_sequencer;

  localparam int NUM_LANES = 36;
  localparam int LANE_W    = 5;
  // A full beat of -16 lanes sums to -576, which needs 11 signed bits, so the
  // tree result is one bit wider here than the default.
  localparam int SUM_W     = 11;
  localparam int TREE_LAT  = 4;
  localparam int ACC_W     = 16;
  localparam int DATA_W    = NUM_LANES * LANE_W;

  logic clk = 1'b0;
  logic RSTN;
  always #5 clk = ~clk;

  cim_tree_sequencer_if #(.NUM_LANES(NUM_LANES), .LANE_W(LANE_W), .SUM_W(SUM_W), .ACC_W(ACC_W)) bus ();

  cim_tree_sequencer #(
    .NUM_LANES(NUM_LANES), .LANE_W(LANE_W), .SUM_W(SUM_W), .TREE_LAT(TREE_LAT), .ACC_W(ACC_W)
  ) dut (
    .clk  (clk),
    .RSTN (RSTN),
    .bus  (bus)
  );

  // Adder tree model: tree_sum shows the sum of tree_data TREE_LAT edges later.
  logic signed [SUM_W-1:0] tp [TREE_LAT];

  function automatic logic signed [SUM_W-1:0] tree_add(input logic [DATA_W-1:0] d);
    int s;
    logic signed [LANE_W-1:0] l;
    s = 0;
    for (int k = 0; k < NUM_LANES; k++) begin
      l = d[k*LANE_W +: LANE_W];
      s = s + int'(l);
    end
    return s[SUM_W-1:0];
  endfunction

  always @(posedge clk) begin
    if (!RSTN) begin
      for (int k = 0; k < TREE_LAT; k++) tp[k] <= '0;
    end else begin
      tp[0] <= tree_add(bus.tree_data);
      for (int k = 1; k < TREE_LAT; k++) tp[k] <= tp[k-1];
    end
  end
  assign bus.tree_sum = tp[TREE_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic signed [LANE_W-1:0] job_lane [16];
  int first_acc, last_acc, done_cyc;
  logic ready_after_start, ready_after_last, timed_out;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one job back-to-back from job_lane[]; records handshake timing.
  task automatic drive_job(input int np, input logic mode, input bit wait_done);
    int w;
    timed_out = 1'b0;
    bus.start      = 1'b1;
    bus.num_passes = np[3:0];
    bus.shift_mode = mode;
    step();
    bus.start = 1'b0;
    ready_after_start = bus.in_ready;
    for (int i = 0; i <= np; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {NUM_LANES{job_lane[i]}};
      w = 0;
      while (!bus.in_ready && w < 20) begin step(); w++; end
      if (!bus.in_ready) timed_out = 1'b1;
      step();
      if (i == 0) first_acc = cyc;
      last_acc = cyc;
    end
    bus.in_valid = 1'b0;
    ready_after_last = bus.in_ready;
    if (wait_done) begin
      w = 0;
      while (!bus.out_valid && w < 40) begin step(); w++; end
      if (!bus.out_valid) timed_out = 1'b1;
      done_cyc = cyc;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    bus.start = 1'b0; bus.num_passes = '0; bus.shift_mode = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    step(); step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b required 0 0 0", bus.in_ready, bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.out_acc !== 16'sd0 || bus.tree_data !== '0) begin
      errors++;
      $display("FAIL reset_data: out_acc=%0d tree_data=%h required 0 0", bus.out_acc, bus.tree_data);
    end
    RSTN = 1'b1;
    // in_valid in IDLE must be ignored
    bus.in_valid = 1'b1;
    bus.in_data  = {NUM_LANES{5'sd7}};
    step();
    checks++;
    if (bus.tree_data !== '0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore_valid: tree_data=%h in_ready=%b busy=%b required 0 0 0", bus.tree_data, bus.in_ready, bus.busy);
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_single_plain();
    job_lane[0] = 5'sd1;
    drive_job(0, 1'b0, 1'b1);
    checks++;
    if (ready_after_start !== 1'b1 || timed_out) begin
      errors++;
      $display("FAIL single_ready: in_ready=%b timeout=%b required 1 0", ready_after_start, timed_out);
    end
    checks++;
    if (bus.out_acc !== 16'sd36) begin
      errors++;
      $display("FAIL single_acc: got %0d required 36", bus.out_acc);
    end
    checks++;
    if (done_cyc - first_acc !== TREE_LAT + 1) begin
      errors++;
      $display("FAIL single_latency: got %0d required %0d", done_cyc - first_acc, TREE_LAT + 1);
    end
    release_result();
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release: busy=%b out_valid=%b required 0 0", bus.busy, bus.out_valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    job_lane[0] = -5'sd16; job_lane[1] = -5'sd16; job_lane[2] = 5'sd15; job_lane[3] = 5'sd0;
    drive_job(3, 1'b0, 1'b1);
    checks++;
    if (last_acc - first_acc !== 3 || timed_out) begin
      errors++;
      $display("FAIL b2b_throughput: span=%0d timeout=%b required 3 0", last_acc - first_acc, timed_out);
    end
    checks++;
    if (ready_after_last !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_drop: in_ready=%b required 0", ready_after_last);
    end
    checks++;
    if (bus.out_acc !== -16'sd612) begin
      errors++;
      $display("FAIL b2b_acc: got %0d required -612", bus.out_acc);
    end
    checks++;
    if (done_cyc - first_acc !== 8) begin
      errors++;
      $display("FAIL b2b_latency: got %0d required 8", done_cyc - first_acc);
    end
    release_result();
    step();
  endtask

  task automatic test_shift_mode();
    job_lane[0] = 5'sd1; job_lane[1] = 5'sd0; job_lane[2] = 5'sd1;
    drive_job(2, 1'b1, 1'b1);
    checks++;
    if (bus.out_acc !== -16'sd108 || timed_out) begin
      errors++;
      $display("FAIL shift_acc: got %0d timeout=%b required -108 0", bus.out_acc, timed_out);
    end
    release_result();
    step();
  endtask

  task automatic test_bubbles();
    int gaps [4];
    logic [DATA_W-1:0] held;
    int w, hold_err, e_last;
    gaps = '{0, 5, 2, 5};
    job_lane[0] = -5'sd16; job_lane[1] = -5'sd16; job_lane[2] = 5'sd15; job_lane[3] = 5'sd0;
    hold_err = 0;
    held = '0;
    bus.start = 1'b1; bus.num_passes = 4'd3; bus.shift_mode = 1'b0;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = {NUM_LANES{5'b01010}};
        step();
        if (i > 0 && bus.tree_data !== held) hold_err++;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = {NUM_LANES{job_lane[i]}};
      held = bus.in_data;
      step();
    end
    e_last = cyc;
    bus.in_valid = 1'b0;
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("FAIL bubble_hold: %0d cycles tree_data changed, required 0", hold_err);
    end
    w = 0;
    while (!bus.out_valid && w < 40) begin step(); w++; end
    checks++;
    if (cyc - e_last !== TREE_LAT + 1) begin
      errors++;
      $display("FAIL bubble_latency: got %0d required %0d", cyc - e_last, TREE_LAT + 1);
    end
    checks++;
    if (bus.out_acc !== -16'sd612 || !bus.out_valid) begin
      errors++;
      $display("FAIL bubble_acc: got %0d valid=%b required -612 1", bus.out_acc, bus.out_valid);
    end
    release_result();
    step();
  endtask

  task automatic test_out_hold();
    job_lane[0] = 5'sd3;
    drive_job(0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      bus.start = k[0];
      bus.num_passes = 4'd5;
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_acc !== 16'sd108 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b acc=%0d busy=%b required 1 108 1", k, bus.out_valid, bus.out_acc, bus.busy);
      end
    end
    bus.start = 1'b0;
    release_result();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: valid=%b busy=%b required 0 0", bus.out_valid, bus.busy);
    end
    job_lane[0] = 5'sd1;
    drive_job(0, 1'b0, 1'b1);
    checks++;
    if (ready_after_start !== 1'b1 || bus.out_acc !== 16'sd36 || timed_out) begin
      errors++;
      $display("FAIL hold_next_job: ready=%b acc=%0d timeout=%b required 1 36 0", ready_after_start, bus.out_acc, timed_out);
    end
    release_result();
    step();
  endtask

  task automatic test_reset_drain();
    int stray;
    for (int i = 0; i < 4; i++) job_lane[i] = 5'sd15;
    drive_job(3, 1'b0, 1'b0);
    step();
    RSTN = 1'b0;
    step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out_acc !== 16'sd0 || bus.tree_data !== '0) begin
      errors++;
      $display("FAIL drain_reset: ready=%b valid=%b busy=%b acc=%0d tree_data=%h required all 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_acc, bus.tree_data);
    end
    RSTN = 1'b1;
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL drain_stray: %0d cycles active after reset, required 0", stray);
    end
    job_lane[0] = 5'sd1;
    drive_job(0, 1'b0, 1'b1);
    checks++;
    if (bus.out_acc !== 16'sd36 || timed_out) begin
      errors++;
      $display("FAIL drain_next_job: acc=%0d timeout=%b required 36 0", bus.out_acc, timed_out);
    end
    release_result();
    step();
  endtask

  initial begin
    test_reset();
    test_single_plain();
    test_back_to_back();
    test_shift_mode();
    test_bubbles();
    test_out_hold();
    test_reset_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cim_tree_sequencer.md
# cim_tree_sequencer

Job sequencer for the CIM 36-lane adder tree. It accepts a job of 1–16 passes and streams one 36-lane beat of signed 5-bit products into the tree per accepted handshake. It tracks each beat through the tree's fixed pipeline latency and folds each returned `tree_sum` into a signed accumulator, in either plain-accumulate or bit-serial shift-add mode. It sits between the CIM array readout (producer) and the core-side result consumer, and owns the tree's input port.

## Interface
- `NUM_LANES`, 36, lanes per beat (matches tree width)
- `LANE_W`, 5, signed bits per lane
- `SUM_W`, 10, signed width of tree result
- `TREE_LAT`, 4, tree latency: clock edges from `tree_data` change to matching `tree_sum`
- `ACC_W`, 16, signed accumulator/result width

Ports:
- `clk`, in, 1: clock. Single clock domain.
- `RSTN`, in, 1: reset. Synchronous, active-low.
- `start`, in, 1: job request. Sampled only in IDLE.
- `num_passes`, in, 4: passes minus 1. Latched at start.
- `shift_mode`, in, 1: 0 = plain accumulate, 1 = bit-serial MSB-first. Latched at start.
- `in_valid`, in, 1: producer beat valid.
- `in_ready`, out, 1: sequencer accepts beat.
- `in_data`, in, NUM_LANES*LANE_W: packed lanes; lane k at [5k+4:5k].
- `tree_data`, out, NUM_LANES*LANE_W: registered drive to the tree's `numbers`.
- `tree_sum`, in, SUM_W signed: tree `finalSum`.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts result.
- `out_acc`, out, ACC_W signed: job result.
- `busy`, out, 1: state != IDLE.

## Operation
- States:
  - IDLE. `start`=1 → FEED at next edge; latch `num_passes`, `shift_mode`; clear issue count and retire count.
  - FEED. `in_ready` = (issued < num_passes+1). On each `in_valid && in_ready`: `tree_data <= in_data`, issued++, push tag into a TREE_LAT+1-deep valid shift pipe. Last beat accepted → DRAIN.
  - DRAIN. `in_ready`=0. Wait for the remaining tags to retire. Last retire → DONE, at the same edge.
  - DONE. `out_valid`=1, `out_acc` stable. `out_valid && out_ready` → IDLE.
- Retire: a tag at the pipe output at an edge means `tree_sum` is added at that edge. `s` = sign-extended `tree_sum` to ACC_W.
  - Plain mode: pass 0 `acc = s`; later passes `acc = acc + s`.
  - Shift mode: pass 0 (sign plane) `acc = -s`; later passes `acc = (acc <<< 1) + s`.
- Arithmetic wraps modulo 2^ACC_W. There is no saturation and no overflow flag.
- Sums are retired in issue order. Untagged `tree_sum` values (idle or bubble cycles) are never used.
- `tree_data` holds its last value when no beat is accepted.
- `start` is ignored outside IDLE.
- `in_valid` outside FEED is ignored, and `in_ready` stays 0.
- Reset values: `in_ready`=0, `out_valid`=0, `out_acc`=0, `tree_data`=0, `busy`=0, state IDLE, tag pipe cleared, counters 0.
- `RSTN` low in any state aborts the job:
  - all state clears at that edge;
  - in-flight tags are discarded;
  - the next job is unaffected by pre-reset tree contents.
- The tree shares `RSTN`.

## Timing
- `start` sampled at edge S → `in_ready` high in the cycle after S (earliest beat accepted at edge S+1).
- Beat accepted at edge E:
  - `tree_data` updates at E;
  - the matching `tree_sum` is valid after edge E+TREE_LAT;
  - it is retired at edge E+TREE_LAT+1.
- Throughput: one beat per cycle with `in_valid` held high. N back-to-back passes from first beat at E finish at E+N-1+TREE_LAT+1.
- `out_valid` rises the cycle after the last retire edge. It holds with `out_acc` stable until an edge with `out_ready`=1; `out_valid` falls after that edge.
- Back-to-back jobs: a `start` in the cycle after leaving DONE is accepted (minimum 1 IDLE cycle).
- `in_ready` is a function of registered state only, with no combinational path from `in_valid`. `out_valid` is registered.

## Test plan
- Single plain pass, num_passes=0, all lanes +1:
  - beat at E → `out_acc`=36;
  - `out_valid` high from the cycle after E+5;
  - `busy` low after handshake.
- Four plain passes back-to-back, lanes all −16, −16, +15, 0 → `out_acc`=−612. `in_ready` drops the cycle after the 4th beat. Result after edge E+8.
- Shift mode, num_passes=2, planes all-1, all-0, all-1 → `out_acc`=−108 (36 × −3).
- Same 4-pass plain job with random `in_valid` bubbles (including 5-cycle gaps) → `out_acc`=−612. No extra or missed retires. `tree_data` holds during bubbles.
- `out_ready` held low 10 cycles in DONE with `start` pulses → `out_valid`/`out_acc` stable, starts ignored. `out_ready`=1 → IDLE. The next `start` is accepted.
- `RSTN` low one cycle during DRAIN of an all-+15 job → all outputs 0 after that edge. A new single all-+1 job then returns 36, with no stale contribution.
